clock_timekeeper: RTL and testbench

- Keeps wall-clock time for the analog clock display.
- Divides the system clock into a 1 Hz tick and counts 12-hour hh:mm:ss.
- Accepts time-sync frames from the SPI receiver over a valid/ready handshake.
- Publishes registered second/minute/hour hand tick positions (0–59) that drive the rotated-rectangle hand generators in the video path. It replaces the pass-through hand driver.

---
 rtl/clock_pkg.sv | 28 ++
 rtl/clock_timekeeper_tick_gen.sv | 29 ++
 rtl/clock_timekeeper.sv | 163 ++++++++++++++++
 tb/tb_clock_timekeeper.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the analog clock timekeeper and hand mapping.
package clock_pkg;

   typedef logic [5:0] tick_t;

   localparam tick_t TICKS_PER_REV  = 6'd60;
   localparam tick_t HOURS_PER_REV  = 6'd12;
   localparam tick_t TICKS_PER_HOUR = 6'd5;
   localparam tick_t MAX_TICK       = TICKS_PER_REV - 6'd1;

   typedef enum logic [1:0] {
      UNSYNC = 2'd0,
      RUN    = 2'd1,
      APPLY  = 2'd2
   } tk_state_t;

   // Minutes-into-hour expressed in hour-hand ticks (mm/12) without a divider.
   function automatic logic [2:0] hour_frac(input tick_t mm);
      logic [2:0] f;
      if (mm >= 6'd48)      f = 3'd4;
      else if (mm >= 6'd36) f = 3'd3;
      else if (mm >= 6'd24) f = 3'd2;
      else if (mm >= 6'd12) f = 3'd1;
      else                  f = 3'd0;
      return f;
   endfunction

endpackage

// File: rtl/clock_timekeeper_tick_gen.sv
// tick_gen: CLK_HZ prescaler; o_tick flags the terminal-count cycle, i_clear zeroes it and suppresses the tick.
module tick_gen #(
   parameter int CLK_HZ = 40_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_en,
   output logic o_tick
);

   localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] TC = CW'(CLK_HZ - 1);

   logic [CW-1:0] r_cnt;
   logic          w_tc;

   assign w_tc   = i_en && !i_clear && (r_cnt == TC);
   assign o_tick = w_tc;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/clock_timekeeper.sv
// clock_timekeeper: 12-hour hh:mm:ss keeper with valid/ready time sync and registered hand tick positions.
// Sync-age counter and stale flag are built only with CLOCK_TIMEKEEPER_SYNC_AGE_EN defined.
module clock_timekeeper
   import clock_pkg::*;
#(
   parameter int CLK_HZ     = 40_000_000,
   parameter int STALE_SECS = 3600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        time_valid,
   output logic        time_ready,
   input  logic [4:0]  hour_in,
   input  logic [5:0]  minute_in,
   input  logic [5:0]  second_in,
   output logic        load_err,
   output logic        running,
   output logic        tick_1hz,
   output logic [5:0]  second,
   output logic [5:0]  minute,
   output logic [5:0]  hour,
   output logic [15:0] sync_age,
   output logic        stale
);

   localparam logic [3:0] LAST_HOUR = 4'(HOURS_PER_REV - 6'd1);

   tk_state_t  r_state, w_state_nxt;
   logic [3:0] r_hh;
   tick_t      r_mm, r_ss;
   tick_t      r_second, r_minute, r_hour;
   logic       r_tick, r_load_err, r_running;

   logic       w_ready, w_in_range, w_xfer, w_accept, w_reject;
   logic       w_en, w_clear, w_tc;
   logic [4:0] w_hh_load;
   tick_t      w_hour_pos;

   assign w_ready    = (r_state != APPLY);
   assign w_in_range = (hour_in <= 5'd23) && (minute_in <= MAX_TICK) && (second_in <= MAX_TICK);
   assign w_xfer     = time_valid && w_ready;
   assign w_accept   = w_xfer && w_in_range;
   assign w_reject   = w_xfer && !w_in_range;
   assign w_hh_load  = (hour_in >= 5'(HOURS_PER_REV)) ? hour_in - 5'(HOURS_PER_REV) : hour_in;

   always_ff @(posedge clk) begin
      if (reset) r_state <= UNSYNC;
      else       r_state <= w_state_nxt;
   end

   // Prescaler is held clear while unsynced and restarts on every accepted frame.
   always_comb begin
      w_state_nxt = r_state;
      w_en        = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         UNSYNC: begin
            w_clear = 1'b1;
            if (w_accept) w_state_nxt = APPLY;
         end
         RUN: begin
            w_en = 1'b1;
            if (w_accept) w_state_nxt = APPLY;
         end
         APPLY: begin
            w_en        = 1'b1;
            w_state_nxt = RUN;
         end
         default: w_state_nxt = UNSYNC;
      endcase
      if (w_accept) w_clear = 1'b1;
   end

   tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_clear),
      .i_en    (w_en),
      .o_tick  (w_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hh <= '0;
         r_mm <= '0;
         r_ss <= '0;
      end else if (w_accept) begin
         r_hh <= w_hh_load[3:0];
         r_mm <= minute_in;
         r_ss <= second_in;
      end else if (w_tc) begin
         if (r_ss == MAX_TICK) begin
            r_ss <= '0;
            if (r_mm == MAX_TICK) begin
               r_mm <= '0;
               r_hh <= (r_hh == LAST_HOUR) ? 4'd0 : r_hh + 4'd1;
            end else begin
               r_mm <= r_mm + 6'd1;
            end
         end else begin
            r_ss <= r_ss + 6'd1;
         end
      end
   end

   assign w_hour_pos = ({2'b00, r_hh} * TICKS_PER_HOUR) + {3'b000, hour_frac(r_mm)};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_second   <= '0;
         r_minute   <= '0;
         r_hour     <= '0;
         r_tick     <= 1'b0;
         r_load_err <= 1'b0;
         r_running  <= 1'b0;
      end else begin
         r_second   <= r_ss;
         r_minute   <= r_mm;
         r_hour     <= w_hour_pos;
         r_tick     <= w_tc;
         r_load_err <= w_reject;
         r_running  <= (r_state != UNSYNC);
      end
   end

   assign time_ready = w_ready;
   assign load_err   = r_load_err;
   assign running    = r_running;
   assign tick_1hz   = r_tick;
   assign second     = r_second;
   assign minute     = r_minute;
   assign hour       = r_hour;

`ifdef CLOCK_TIMEKEEPER_SYNC_AGE_EN
   logic [15:0] r_sync_age, w_age_nxt;
   logic        r_stale;

   always_comb begin
      w_age_nxt = r_sync_age;
      if (w_accept)                               w_age_nxt = '0;
      else if (w_tc && (r_sync_age != 16'hFFFF)) w_age_nxt = r_sync_age + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync_age <= '0;
         r_stale    <= 1'b0;
      end else begin
         r_sync_age <= w_age_nxt;
         r_stale    <= (w_state_nxt != UNSYNC) && ({16'd0, w_age_nxt} >= 32'(STALE_SECS));
      end
   end

   assign sync_age = r_sync_age;
   assign stale    = r_stale;
`else
   logic [31:0] w_unused_stale_secs;
   assign w_unused_stale_secs = 32'(STALE_SECS);
   assign sync_age = '0;
   assign stale    = 1'b0;
`endif

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scoreboard bench for clock_timekeeper at CLK_HZ=10, STALE_SECS=3; monitor checks load, tick and error events.
module tb_clock_timekeeper;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        time_valid = 1'b0;
   logic [4:0]  hour_in = '0;
   logic [5:0]  minute_in = '0;
   logic [5:0]  second_in = '0;
   logic        time_ready, load_err, running, tick_1hz, stale;
   logic [5:0]  second, minute, hour;
   logic [15:0] sync_age;

   clock_timekeeper #(.CLK_HZ(10), .STALE_SECS(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .time_valid (time_valid),
      .time_ready (time_ready),
      .hour_in    (hour_in),
      .minute_in  (minute_in),
      .second_in  (second_in),
      .load_err   (load_err),
      .running    (running),
      .tick_1hz   (tick_1hz),
      .second     (second),
      .minute     (minute),
      .hour       (hour),
      .sync_age   (sync_age),
      .stale      (stale)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum {EV_LOAD, EV_TICK, EV_ERR} ev_t;
   typedef struct {
      ev_t kind;
      int  hr;
      int  mn;
      int  sc;
      int  at;
      int  run;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int n_ticks = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push(input ev_t k, input int hr, input int mn, input int sc,
                                input int at, input int run);
      exp_t e;
      e.kind = k; e.hr = hr; e.mn = mn; e.sc = sc; e.at = at; e.run = run;
      q.push_back(e);
   endfunction

   task automatic take(input ev_t k, output exp_t e, output bit ok);
      ok = 1'b0;
      if (q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_%s: got event at cycle %0d, want none", k.name(), cyc);
         return;
      end
      e = q.pop_front();
      check({"event_kind_", k.name()}, int'(k), int'(e.kind));
      ok = (e.kind == k);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_time_ready"}, time_ready, 1);
      check({tag, "_running"}, running, 0);
      check({tag, "_load_err"}, load_err, 0);
      check({tag, "_tick"}, tick_1hz, 0);
      check({tag, "_second"}, second, 0);
      check({tag, "_minute"}, minute, 0);
      check({tag, "_hour"}, hour, 0);
      check({tag, "_sync_age"}, sync_age, 0);
      check({tag, "_stale"}, stale, 0);
   endtask

   // Present a frame so that it is sampled at edge n, holding valid for 'hold' edges.
   task automatic frame_at(input int n, input int h, input int m, input int s, input int hold);
      if (cyc >= n) begin
         total++;
         bad++;
         $display("FAIL frame_sched: got cycle %0d want before %0d", cyc, n);
         return;
      end
      while (cyc < n - 1) @(negedge clk);
      time_valid = 1'b1;
      hour_in    = 5'(h);
      minute_in  = 6'(m);
      second_in  = 6'(s);
      repeat (hold) @(negedge clk);
      time_valid = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Monitor: error pulses, post-APPLY hand values and post-tick hand values.
   initial begin : monitor
      bit   prev_apply, prev_tick, ok;
      int   tick_at;
      exp_t e;
      prev_apply = 1'b0;
      prev_tick  = 1'b0;
      tick_at    = 0;
      forever begin
         @(negedge clk);
         if (load_err === 1'b1) begin
            take(EV_ERR, e, ok);
            if (ok) check("err_running", running, e.run);
         end
         if (prev_apply) begin
            take(EV_LOAD, e, ok);
            if (ok) begin
               check("load_hour", hour, e.hr);
               check("load_minute", minute, e.mn);
               check("load_second", second, e.sc);
               check("load_running", running, e.run);
            end
         end
         if (prev_tick) begin
            take(EV_TICK, e, ok);
            if (ok) begin
               check("tick_cycle", tick_at, e.at);
               check("tick_hour", hour, e.hr);
               check("tick_minute", minute, e.mn);
               check("tick_second", second, e.sc);
            end
         end
         if (tick_1hz === 1'b1) n_ticks++;
         prev_apply = (time_ready !== 1'b1);
         prev_tick  = (tick_1hz === 1'b1);
         tick_at    = cyc;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int a, b, c;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals("por");
      repeat (50) @(negedge clk);
      check("idle_ticks", n_ticks, 0);
      check("idle_running", running, 0);

      // Resyncs land on terminal-count edges so load-wins is exercised each time.
      a = cyc + 5;
      push(EV_LOAD, 16, 15, 30, 0, 1);
      push(EV_TICK, 16, 15, 31, a + 10, 0);
      frame_at(a, 15, 15, 30, 1);

      push(EV_LOAD, 59, 59, 59, 0, 1);
      push(EV_TICK, 0, 0, 0, a + 30, 0);
      frame_at(a + 20, 23, 59, 59, 2);

      push(EV_LOAD, 5, 0, 0, 0, 1);
      push(EV_TICK, 5, 0, 1, a + 50, 0);
      frame_at(a + 40, 1, 0, 0, 1);

`ifndef CLOCK_TIMEKEEPER_SYNC_AGE_EN
      wait_cyc(a + 55);
      check("noage_sync_age", sync_age, 0);
      check("noage_stale", stale, 0);
`endif

      push(EV_ERR, 0, 0, 0, 0, 1);
      push(EV_TICK, 5, 0, 2, a + 60, 0);
      frame_at(a + 60, 5, 60, 0, 1);

      wait_cyc(a + 65);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("midrst");
      reset = 1'b0;
      check("q_after_run", q.size(), 0);

      c = cyc + 3;
      push(EV_ERR, 0, 0, 0, 0, 0);
      frame_at(c, 1, 60, 0, 1);
      push(EV_ERR, 0, 0, 0, 0, 0);
      frame_at(c + 3, 24, 0, 0, 1);
      push(EV_ERR, 0, 0, 0, 0, 0);
      frame_at(c + 6, 0, 0, 60, 1);
      repeat (3) @(negedge clk);
      check("err_unsync_running", running, 0);
      check("err_unsync_hands", {hour, minute, second}, 0);
      check("err_unsync_ready", time_ready, 1);

`ifdef CLOCK_TIMEKEEPER_SYNC_AGE_EN
      b = cyc + 5;
      push(EV_LOAD, 0, 0, 0, 0, 1);
      push(EV_TICK, 0, 0, 1, b + 10, 0);
      push(EV_TICK, 0, 0, 2, b + 20, 0);
      push(EV_TICK, 0, 0, 3, b + 30, 0);
      frame_at(b, 0, 0, 0, 1);
      wait_cyc(b + 1);
      check("age_after_sync", sync_age, 0);
      wait_cyc(b + 21);
      check("age_two", sync_age, 2);
      check("stale_two", stale, 0);
      wait_cyc(b + 31);
      check("age_three", sync_age, 3);
      check("stale_three", stale, 1);
      push(EV_LOAD, 10, 0, 0, 0, 1);
      frame_at(b + 35, 2, 0, 0, 1);
      check("age_cleared", sync_age, 0);
      check("stale_cleared", stale, 0);
      wait_cyc(b + 38);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("agerst");
      reset = 1'b0;
`else
      b = 0;
`endif

      repeat (5) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
